wb_arbiter_std2pipe: RTL and testbench

- Two-master arbiter and protocol bridge.
- Shares one Wishbone B4 pipelined slave between two standard (classic) Wishbone masters.
- Grants the slave round-robin, converts each classic strobe into a single pipelined request, forwards acks, and bounds slave response time with a watchdog.
- Sits between the master-side interconnect and the pipelined slave wrapper.

---
 rtl/wb_arbiter_std2pipe.sv | 147 ++++++++++++++
 tb/tb_wb_arbiter_std2pipe.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter_std2pipe.sv
// Round-robin arbiter letting two classic Wishbone masters share one pipelined slave.
// Each classic strobe becomes exactly one pipelined request; a watchdog errors out silent slaves.
module wb_arbiter_std2pipe #(
  parameter int adr_width = 16,
  parameter int dat_width = 16,
  parameter int timeout   = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 m0_cyc,
  input  logic                 m0_stb,
  input  logic                 m0_we,
  input  logic [adr_width-1:0] m0_adr,
  input  logic [dat_width-1:0] m0_dat_m,
  output logic                 m0_ack,
  output logic                 m0_err,
  output logic [dat_width-1:0] m0_dat_s,
  input  logic                 m1_cyc,
  input  logic                 m1_stb,
  input  logic                 m1_we,
  input  logic [adr_width-1:0] m1_adr,
  input  logic [dat_width-1:0] m1_dat_m,
  output logic                 m1_ack,
  output logic                 m1_err,
  output logic [dat_width-1:0] m1_dat_s,
  output logic                 s_cyc,
  output logic                 s_stb,
  output logic                 s_we,
  output logic [adr_width-1:0] s_adr,
  output logic [dat_width-1:0] s_dat_m,
  input  logic                 s_stall,
  input  logic                 s_ack,
  input  logic [dat_width-1:0] s_dat_s
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_WAIT = 2'd2} state_t;

  localparam logic [7:0] TO = 8'(timeout);

  state_t     r_state, w_state_nxt;
  logic       r_gvld, w_gvld_nxt;
  logic       r_gidx, w_gidx_nxt;
  logic       r_rr_last, w_rr_nxt;
  logic [7:0] r_wd, w_wd_nxt;
  logic [1:0] w_req;
  logic       w_gcyc, w_greq, w_pick;
  logic       w_scyc, w_sstb, w_ack, w_err;

  assign w_req  = {m1_cyc & m1_stb, m0_cyc & m0_stb};
  assign w_gcyc = r_gidx ? m1_cyc : m0_cyc;
  assign w_greq = w_req[r_gidx];
  // Tie goes to whoever was not granted last; otherwise the lone requester wins.
  assign w_pick = (&w_req) ? ~r_rr_last : w_req[1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_gvld    <= 1'b0;
      r_gidx    <= 1'b0;
      r_rr_last <= 1'b1;
      r_wd      <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_gvld    <= w_gvld_nxt;
      r_gidx    <= w_gidx_nxt;
      r_rr_last <= w_rr_nxt;
      r_wd      <= w_wd_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_gvld_nxt  = r_gvld;
    w_gidx_nxt  = r_gidx;
    w_rr_nxt    = r_rr_last;
    w_wd_nxt    = r_wd;
    w_scyc      = 1'b0;
    w_sstb      = 1'b0;
    w_ack       = 1'b0;
    w_err       = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_wd_nxt = '0;
        if (r_gvld) begin
          // Granted master keeps the bus locked for as long as it holds cyc.
          if (w_gcyc) begin
            w_scyc = 1'b1;
            if (w_greq) w_state_nxt = S_REQ;
          end else begin
            w_gvld_nxt = 1'b0;
          end
        end else if (|w_req) begin
          w_gvld_nxt  = 1'b1;
          w_gidx_nxt  = w_pick;
          w_rr_nxt    = w_pick;
          w_state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        if (!w_gcyc) begin
          w_gvld_nxt  = 1'b0;
          w_wd_nxt    = '0;
          w_state_nxt = S_IDLE;
        end else begin
          w_scyc = 1'b1;
          w_sstb = 1'b1;
          if (!s_stall) w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!w_gcyc) begin
          w_gvld_nxt  = 1'b0;
          w_wd_nxt    = '0;
          w_state_nxt = S_IDLE;
        end else if (s_ack) begin
          w_scyc      = 1'b1;
          w_ack       = 1'b1;
          w_wd_nxt    = '0;
          w_state_nxt = S_IDLE;
        end else if (r_wd == TO) begin
          // Slave went silent: error the master and drop the cycle so a late ack lands nowhere.
          w_err       = 1'b1;
          w_gvld_nxt  = 1'b0;
          w_wd_nxt    = '0;
          w_state_nxt = S_IDLE;
        end else begin
          w_scyc   = 1'b1;
          w_wd_nxt = r_wd + 8'd1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign s_cyc    = w_scyc;
  assign s_stb    = w_sstb;
  assign s_we     = r_gidx ? m1_we    : m0_we;
  assign s_adr    = r_gidx ? m1_adr   : m0_adr;
  assign s_dat_m  = r_gidx ? m1_dat_m : m0_dat_m;
  assign m0_ack   = w_ack & ~r_gidx;
  assign m1_ack   = w_ack &  r_gidx;
  assign m0_err   = w_err & ~r_gidx;
  assign m1_err   = w_err &  r_gidx;
  assign m0_dat_s = s_dat_s;
  assign m1_dat_s = s_dat_s;

endmodule

// File: tb/tb_wb_arbiter_std2pipe.sv
// Bench for wb_arbiter_std2pipe: classic master drivers, a pipelined slave with memory,
// and a transaction-level model of memory contents, service order and latency.
module tb_wb_arbiter_std2pipe;
  localparam int TMO = 15;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        m0_cyc, m0_stb, m0_we, m0_ack, m0_err;
  logic [15:0] m0_adr, m0_dat_m, m0_dat_s;
  logic        m1_cyc, m1_stb, m1_we, m1_ack, m1_err;
  logic [15:0] m1_adr, m1_dat_m, m1_dat_s;
  logic        s_cyc, s_stb, s_we, s_stall;
  logic        s_ack = 1'b0;
  logic [15:0] s_adr, s_dat_m;
  logic [15:0] s_dat_s = 16'h0;

  wb_arbiter_std2pipe #(.adr_width(16), .dat_width(16), .timeout(TMO)) dut (
    .clk(clk), .rst(rst),
    .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_adr(m0_adr), .m0_dat_m(m0_dat_m),
    .m0_ack(m0_ack), .m0_err(m0_err), .m0_dat_s(m0_dat_s),
    .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_adr(m1_adr), .m1_dat_m(m1_dat_m),
    .m1_ack(m1_ack), .m1_err(m1_err), .m1_dat_s(m1_dat_s),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr), .s_dat_m(s_dat_m),
    .s_stall(s_stall), .s_ack(s_ack), .s_dat_s(s_dat_s)
  );

  // Pipelined slave: stalls each request stall_req cycles, acks one cycle after acceptance.
  logic [15:0] smem [0:255];
  int stall_req = 0;
  bit no_ack    = 1'b0;
  int stall_cnt = 0, stb_cyc = 0, accepts = 0;
  assign s_stall = s_stb && (stall_cnt < stall_req);
  always @(posedge clk) begin
    s_ack <= 1'b0;
    if (s_cyc && s_stb) begin
      stb_cyc <= stb_cyc + 1;
      if (s_stall) stall_cnt <= stall_cnt + 1;
      else begin
        stall_cnt <= 0;
        accepts   <= accepts + 1;
        if (s_we) smem[s_adr[7:0]] <= s_dat_m;
        s_dat_s <= s_we ? 16'h0 : smem[s_adr[7:0]];
        s_ack   <= !no_ack;
      end
    end
  end

  typedef struct { bit we; logic [15:0] adr; logic [15:0] dat; bit hold; int gap; } txn_t;
  txn_t q0[$], q1[$];
  txn_t cur [2];
  bit   busy [2];
  bit   lock [2];
  int   gapc [2];
  int   t_start [2];
  int   served[$], lat[$], errq[$], ackc[$];
  logic [15:0] exp_mem [0:255];
  bit   known [0:255];
  int   checks = 0, failures = 0, cyc_n = 0, cyc_low = 0, model_last = 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push(input int k, input bit we, input int adr, input int dat, input bit hold, input int gap);
    txn_t t;
    t.we = we; t.adr = 16'(adr); t.dat = 16'(dat); t.hold = hold; t.gap = gap;
    if (k == 0) q0.push_back(t); else q1.push_back(t);
  endtask

  task automatic clear_logs();
    served.delete(); lat.delete(); errq.delete(); ackc.delete(); cyc_low = 0;
  endtask

  task automatic drive_pins();
    m0_cyc = busy[0] | lock[0]; m0_stb = busy[0]; m0_we = cur[0].we;
    m0_adr = cur[0].adr; m0_dat_m = cur[0].dat;
    m1_cyc = busy[1] | lock[1]; m1_stb = busy[1]; m1_we = cur[1].we;
    m1_adr = cur[1].adr; m1_dat_m = cur[1].dat;
  endtask

  // Classic masters: one transfer at a time, stb held until ack/err, then gap or back-to-back.
  task automatic run(input int budget);
    int n;
    logic [1:0] a, e;
    n = 0;
    while (q0.size() != 0 || q1.size() != 0 || busy[0] || busy[1] || gapc[0] != 0 || gapc[1] != 0) begin
      if (n == budget) begin
        checks++; failures++;
        $error("FAIL run_budget cycles=%0d limit=%0d", n, budget);
        q0.delete(); q1.delete(); busy[0] = 0; busy[1] = 0; gapc[0] = 0; gapc[1] = 0;
        lock[0] = 0; lock[1] = 0;
        break;
      end
      tick(); cyc_n++; n++;
      for (int k = 0; k < 2; k++) begin
        if (!busy[k]) begin
          if (gapc[k] > 0) gapc[k]--;
          else if ((k == 0 ? q0.size() : q1.size()) > 0) begin
            cur[k] = (k == 0) ? q0.pop_front() : q1.pop_front();
            busy[k] = 1'b1; lock[k] = 1'b0; t_start[k] = cyc_n;
          end
        end
      end
      drive_pins();
      #1;
      a = {m1_ack, m0_ack};
      e = {m1_err, m0_err};
      if (ackc.size() > 0 && busy[0] && !s_cyc) cyc_low++;
      for (int k = 0; k < 2; k++) begin
        if (a[k] | e[k]) begin
          chk($sformatf("ack_err_excl_m%0d", k), 32'(a[k] & e[k]), 32'd0);
          chk($sformatf("resp_to_idle_m%0d", k), 32'(busy[k]), 32'd1);
          if (e[k]) chk("err_drops_cyc", 32'(s_cyc), 32'd0);
          if (busy[k]) begin
            served.push_back(k); lat.push_back(cyc_n - t_start[k]);
            errq.push_back(int'(e[k])); ackc.push_back(cyc_n);
            if (a[k] && cur[k].we) begin
              exp_mem[cur[k].adr[7:0]] = cur[k].dat; known[cur[k].adr[7:0]] = 1'b1;
            end else if (a[k] && known[cur[k].adr[7:0]]) begin
              chk($sformatf("read_m%0d_adr%0d", k, cur[k].adr), 32'(k == 1 ? m1_dat_s : m0_dat_s),
                  32'(exp_mem[cur[k].adr[7:0]]));
            end
            busy[k] = 1'b0;
            lock[k] = a[k] & cur[k].hold;
            gapc[k] = lock[k] ? 0 : cur[k].gap;
          end
        end
      end
    end
    tick(); drive_pins();
    tick();
  endtask

  initial begin
    #3_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "bench did not finish");
  end

  initial begin
    int acc0, stb0, bad, nerr, sr;
    for (int k = 0; k < 2; k++) begin
      busy[k] = 0; lock[k] = 0; gapc[k] = 0; t_start[k] = 0;
      cur[k].we = 0; cur[k].adr = '0; cur[k].dat = '0; cur[k].hold = 0; cur[k].gap = 0;
    end
    drive_pins();
    // Reset held with m0 requesting: nothing may reach slave or masters.
    rst = 1'b0;
    m0_cyc = 1'b1; m0_stb = 1'b1;
    repeat (3) tick();
    chk("rst_s_cyc", 32'(s_cyc), 32'd0);
    chk("rst_s_stb", 32'(s_stb), 32'd0);
    chk("rst_m0_ack", 32'(m0_ack), 32'd0);
    chk("rst_m1_ack", 32'(m1_ack), 32'd0);
    chk("rst_errs", 32'({m0_err, m1_err}), 32'd0);
    drive_pins();
    tick(); rst = 1'b1; tick();

    // Contention straight out of reset.
    clear_logs();
    push(0, 1, 5, 16'h00AA, 0, 1); push(1, 1, 6, 16'h00BB, 0, 1);
    run(100);
    chk("rrA_count", 32'(served.size()), 32'd2);
    chk("rrA_first", 32'(served[0]), 32'(1 - model_last));
    chk("rrA_second", 32'(served[1]), 32'(model_last));
    chk("rrA_win_lat", 32'(lat[0]), 32'd2);
    chk("rrA_lose_lat", 32'(lat[1]), 32'd6);

    // Single master writes with a gap cycle between them.
    clear_logs(); acc0 = accepts; stb0 = stb_cyc;
    for (int i = 1; i <= 10; i++) push(0, 1, i, 100 + i, 0, 1);
    run(400);
    chk("wr_count", 32'(served.size()), 32'd10);
    bad = 0;
    foreach (lat[i]) if (lat[i] != 2) bad++;
    chk("wr_lat_bad", 32'(bad), 32'd0);
    chk("wr_accepts", 32'(accepts - acc0), 32'd10);
    chk("wr_stb_cycles", 32'(stb_cyc - stb0), 32'd10);
    clear_logs();
    for (int i = 1; i <= 10; i++) push(0, 0, i, 0, 0, 1);
    run(400);
    chk("rd_count", 32'(served.size()), 32'd10);
    chk("rd_adr10_model", 32'(exp_mem[10]), 32'd110);
    model_last = 0;

    // Same contention again after m0 was served last: m1 should now win.
    clear_logs();
    push(0, 1, 5, 16'h00AA, 0, 1); push(1, 1, 6, 16'h00BB, 0, 1);
    run(100);
    chk("rrB_first", 32'(served[0]), 32'(1 - model_last));
    chk("rrB_second", 32'(served[1]), 32'(model_last));

    // Back-to-back: stb held across transfers.
    clear_logs(); acc0 = accepts;
    for (int i = 11; i <= 20; i++) push(0, 1, i, 200 + i, i != 20, 1);
    run(400);
    chk("b2b_count", 32'(served.size()), 32'd10);
    chk("b2b_cyc_low", 32'(cyc_low), 32'd0);
    chk("b2b_accepts", 32'(accepts - acc0), 32'd10);
    bad = 0;
    for (int i = 1; i < ackc.size(); i++) if (ackc[i] - ackc[i-1] != 3) bad++;
    chk("b2b_spacing_bad", 32'(bad), 32'd0);
    clear_logs();
    for (int i = 11; i <= 20; i++) push(0, 0, i, 0, i != 20, 1);
    run(400);
    chk("b2b_rd_count", 32'(served.size()), 32'd10);

    // Stalled slave on an m1 write.
    clear_logs(); acc0 = accepts; stb0 = stb_cyc; stall_req = 4;
    push(1, 1, 40, 16'h1234, 0, 1);
    run(100);
    stall_req = 0;
    chk("stall_count", 32'(served.size()), 32'd1);
    chk("stall_stb_cycles", 32'(stb_cyc - stb0), 32'd5);
    chk("stall_accepts", 32'(accepts - acc0), 32'd1);
    chk("stall_lat", 32'(lat[0]), 32'd6);

    // Silent slave: watchdog error on m0, then m1 served normally.
    clear_logs(); no_ack = 1'b1;
    push(0, 0, 3, 0, 0, 1);
    run(100);
    no_ack = 1'b0;
    chk("to_err", 32'(errq[0]), 32'd1);
    chk("to_lat", 32'(lat[0]), 32'(2 + TMO));
    clear_logs();
    push(1, 0, 3, 0, 0, 1);
    run(100);
    chk("post_to_ok", 32'(errq[0]), 32'd0);
    chk("post_to_lat", 32'(lat[0]), 32'd2);

    // Master abort while waiting for a response.
    no_ack = 1'b1;
    tick(); m0_cyc = 1'b1; m0_stb = 1'b1; m0_we = 1'b0; m0_adr = 16'd7;
    tick(); #1 chk("abort_req_stb", 32'(s_stb), 32'd1);
    tick(); #1 chk("abort_wait_cyc", 32'({s_cyc, s_stb}), 32'b10);
    tick(); m0_cyc = 1'b0; m0_stb = 1'b0;
    #1 chk("abort_cyc_drop", 32'({s_cyc, s_stb}), 32'b00);
    bad = 0;
    repeat (TMO + 5) begin
      tick();
      if (m0_ack || m0_err || s_cyc) bad++;
    end
    chk("abort_quiet", 32'(bad), 32'd0);
    no_ack = 1'b0;
    clear_logs();
    push(1, 0, 7, 0, 0, 1);
    run(100);
    chk("post_abort_lat", 32'(lat[0]), 32'd2);

    // Reset asserted mid-REQ after an m0 grant; m0 regains priority afterwards.
    acc0 = accepts;
    tick(); m0_cyc = 1'b1; m0_stb = 1'b1; m0_we = 1'b1; m0_adr = 16'd50; m0_dat_m = 16'hDEAD;
    tick(); #1 chk("rstmid_req_stb", 32'(s_stb), 32'd1);
    #3 rst = 1'b0;
    #1 chk("rstmid_outs", 32'({s_cyc, s_stb, m0_ack, m0_err}), 32'd0);
    tick(); m0_cyc = 1'b0; m0_stb = 1'b0;
    tick(); rst = 1'b1; tick();
    chk("rstmid_no_accept", 32'(accepts - acc0), 32'd0);
    model_last = 1;
    clear_logs();
    push(0, 1, 5, 16'h0055, 0, 1); push(1, 1, 6, 16'h0066, 0, 1);
    run(100);
    chk("rst_rr_first", 32'(served[0]), 32'(1 - model_last));

    // Randomized traffic against the memory model.
    clear_logs();
    for (int i = 0; i < 32; i++) push(0, 1, i, int'($urandom_range(0, 16'hFFFF)), i != 31, 1);
    run(400);
    chk("rnd_init_count", 32'(served.size()), 32'd32);
    for (int b = 0; b < 4; b++) begin
      clear_logs(); acc0 = accepts; stb0 = stb_cyc;
      sr = int'($urandom_range(0, 2));
      stall_req = sr;
      for (int i = 0; i < 12; i++)
        push(int'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), int'($urandom_range(0, 31)),
             int'($urandom_range(0, 16'hFFFF)), 0, int'($urandom_range(1, 3)));
      run(2000);
      stall_req = 0;
      nerr = 0;
      foreach (errq[i]) nerr += errq[i];
      chk($sformatf("rnd%0d_count", b), 32'(served.size()), 32'd12);
      chk($sformatf("rnd%0d_errs", b), 32'(nerr), 32'd0);
      chk($sformatf("rnd%0d_accepts", b), 32'(accepts - acc0), 32'd12);
      chk($sformatf("rnd%0d_stb", b), 32'(stb_cyc - stb0), 32'(12 * (1 + sr)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
